// File: rtl/imem_fetch_unit.sv
// Instruction memory with NOP fill after reset, program-load port and a
// request/response fetch handshake. Define IMEM_PARITY_EN to add per-word parity.
module imem_fetch_unit #(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h1800_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic              load_par_flip,
`endif
  output logic              load_ready,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q;
  logic [AW-1:0]     cnt_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_instr_q;
  logic [1:0]        rsp_err_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
  logic              par_q [DEPTH];
  logic              wr_par_d;
  logic              rd_par_d;
`endif

  // Misaligned takes priority over out-of-range.
  function automatic logic [1:0] addr_chk(input logic [ADDR_W-1:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (a[ADDR_W-1:AW+2] != '0) return 2'b10;
    return 2'b00;
  endfunction

  logic              fetch_acc, load_acc, bypass;
  logic [1:0]        f_err, l_err;
  logic [AW-1:0]     f_idx, l_idx;
  logic              wr_en_d;
  logic [AW-1:0]     wr_idx_d;
  logic [DATA_W-1:0] wr_data_d, rd_data_d, instr_d;
  logic [1:0]        err_d;

  assign busy        = (state_q == INIT);
  assign load_ready  = (state_q == RUN);
  assign fetch_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
  assign fetch_acc   = fetch_req && fetch_ready;
  assign load_acc    = load_en && load_ready;
  assign f_err       = addr_chk(fetch_addr);
  assign l_err       = addr_chk(load_addr);
  assign f_idx       = fetch_addr[AW+1:2];
  assign l_idx       = load_addr[AW+1:2];
  assign bypass      = load_acc && (l_err == 2'b00) && (l_idx == f_idx);

  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = cnt_q;
    wr_data_d = NOP_WORD;
    if (state_q == INIT) begin
      wr_en_d = 1'b1;
    end else if (load_acc && (l_err == 2'b00)) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = l_idx;
      wr_data_d = load_data;
    end
  end

`ifdef IMEM_PARITY_EN
  assign wr_par_d = ^wr_data_d ^ ((state_q == RUN) && load_par_flip);
  assign rd_par_d = bypass ? wr_par_d : par_q[f_idx];
`endif

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[wr_idx_d] <= wr_data_d;
`ifdef IMEM_PARITY_EN
      par_q[wr_idx_d] <= wr_par_d;
`endif
    end
  end

  // Write-first: a same-cycle load to the fetched word is forwarded.
  assign rd_data_d = bypass ? load_data : mem_q[f_idx];

  always_comb begin
    instr_d = NOP_WORD;
    err_d   = f_err;
    if (f_err == 2'b00) begin
      instr_d = rd_data_d;
`ifdef IMEM_PARITY_EN
      if ((^rd_data_d) != rd_par_d) err_d = 2'b11;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= NOP_WORD;
      rsp_err_q   <= 2'b00;
      rsp_addr_q  <= '0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(DEPTH - 1)) state_q <= RUN;
        end
        RUN: begin
          if (fetch_acc) begin
            rsp_valid_q <= 1'b1;
            rsp_instr_q <= instr_d;
            rsp_err_q   <= err_d;
            rsp_addr_q  <= fetch_addr;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: a word model computes each expected
// response when a fetch is accepted; responses are compared while they are held.
module tb_imem_fetch_unit;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h1800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_err;
  logic [31:0] rsp_addr;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        busy;
`ifdef IMEM_PARITY_EN
  logic        load_par_flip = 1'b0;
`endif

  imem_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_err(rsp_err), .rsp_addr(rsp_addr),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_par_flip(load_par_flip),
`endif
    .load_ready(load_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
    logic [31:0] addr;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] mdl_mem [DEPTH];
  logic        mdl_flip [DEPTH];
  logic        mdl_run;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i]  = NOP;
      mdl_flip[i] = 1'b0;
    end
    mdl_run = 1'b0;
    exp_q.delete();
  endtask

  function automatic rsp_t model_fetch(input logic [31:0] a);
    rsp_t r;
    r.addr = a;
    if (a[1:0] != 2'b00) begin
      r.instr = NOP; r.err = 2'b01;
    end else if (a >= 32'(DEPTH * 4)) begin
      r.instr = NOP; r.err = 2'b10;
    end else begin
      r.instr = mdl_mem[a[11:2]];
      r.err   = mdl_flip[a[11:2]] ? 2'b11 : 2'b00;
    end
    return r;
  endfunction

  // Inputs are set just after an edge; this samples, updates the model and advances one cycle.
  task automatic step();
    logic exp_rdy;
    #1;
    exp_rdy = mdl_run && ((exp_q.size() == 0) || rsp_ready);
    check("fetch_ready", 64'(fetch_ready), 64'(exp_rdy));
    check("load_ready", 64'(load_ready), 64'(mdl_run));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rsp_instr", 64'(rsp_instr), 64'(exp_q[0].instr));
      check("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
      check("rsp_addr", 64'(rsp_addr), 64'(exp_q[0].addr));
      if (rsp_ready) void'(exp_q.pop_front());
    end
    if (load_en && mdl_run && load_addr[1:0] == 2'b00 && load_addr < 32'(DEPTH * 4)) begin
      mdl_mem[load_addr[11:2]] = load_data;
`ifdef IMEM_PARITY_EN
      mdl_flip[load_addr[11:2]] = load_par_flip;
`else
      mdl_flip[load_addr[11:2]] = 1'b0;
`endif
    end
    if (fetch_req && exp_rdy) exp_q.push_back(model_fetch(fetch_addr));
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    step();
    fetch_req = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic run_init();
    for (int i = 0; i < DEPTH; i++) begin
      check("busy_init", 64'(busy), 64'd1);
      step();
    end
    mdl_run = 1'b1;
    check("busy_run", 64'(busy), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_instr", 64'(rsp_instr), 64'(NOP));
    check("reset_err", 64'(rsp_err), 64'd0);
    check("reset_addr", 64'(rsp_addr), 64'd0);
    check("reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b1;
    run_init();

    rsp_ready = 1'b1;
    do_fetch(32'h10);
    step();

    do_load(32'h0, 32'h1800_000A);
    do_load(32'h4, 32'h0800_0001);
    do_fetch(32'h0);
    do_fetch(32'h4);
    step();

    // Stall with a second request pending; it must wait for the consume.
    fetch_req = 1'b1; fetch_addr = 32'h8;
    step();
    rsp_ready = 1'b0; fetch_addr = 32'hC;
    repeat (3) step();
    rsp_ready = 1'b1;
    step();
    fetch_req = 1'b0;
    step();

    do_fetch(32'h6);
    do_fetch(32'h1000);
    do_load(32'h1000, 32'h1234_5678);
    do_load(32'h2, 32'h8765_4321);
    do_fetch(32'h0);
    do_fetch(32'h4);
    step();

    load_en = 1'b1; load_addr = 32'h20; load_data = 32'hDEAD_BEEF;
    do_fetch(32'h20);
    load_en = 1'b0;
    step();

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rsp_ready = ($urandom_range(0, 3) != 0);
      load_en   = ($urandom_range(0, 2) == 0);
      load_addr = 32'($urandom_range(0, 15)) << 2;
      load_data = $urandom;
      fetch_req = ($urandom_range(0, 3) != 0);
      if (sel == 0)      fetch_addr = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
      else if (sel == 1) fetch_addr = 32'($urandom_range(0, 63)) | 32'h1;
      else               fetch_addr = 32'($urandom_range(0, 15)) << 2;
      step();
    end
    load_en = 1'b0;

    // Reset with a response held: valid must drop at once and memory refill.
    fetch_req = 1'b1; fetch_addr = 32'h20; rsp_ready = 1'b0;
    step();
    fetch_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd1);
    check("midrst_fready", 64'(fetch_ready), 64'd0);
    model_reset();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_init();
    do_fetch(32'h20);
    do_fetch(32'h0);
    step();

`ifdef IMEM_PARITY_EN
    load_par_flip = 1'b1;
    do_load(32'h20, 32'h0000_0003);
    load_par_flip = 1'b0;
    do_fetch(32'h20);
    do_fetch(32'h24);
    step();
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
Parametrised successor to the processor's combinational instruction memory. It adds a synchronous word-addressed RAM, a NOP-fill sequence after reset, a runtime program-load write port, and a request/response fetch handshake with backpressure and address-error reporting. It sits between the PC/fetch stage and the decode stage. It is the single source of instructions for the core.

Parameters:
ADDR_W, 32, width of byte address on the fetch and load ports
DATA_W, 32, instruction width in bits
DEPTH, 1024, number of instruction words; power of two, minimum 4
NOP_WORD, 32'h1800_0000, fill/error word (ADDI R0,R0,0); DATA_W wide

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request valid
fetch_addr  in  ADDR_W  byte address of the requested instruction
fetch_ready  out  1  request accepted when fetch_req && fetch_ready
rsp_valid  out  1  response word available
rsp_ready  in  1  decode stage consumes the response
rsp_instr  out  DATA_W  fetched instruction
rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 parity (optional)
rsp_addr  out  ADDR_W  echo of the accepted fetch_addr
load_en  in  1  program-load write strobe
load_addr  in  ADDR_W  byte address of the load write
load_data  in  DATA_W  word to write
load_ready  out  1  load accepted when load_en && load_ready
busy  out  1  high while in INIT

Behaviour:
- States:
  - INIT: entered on reset. A word counter runs 0..DEPTH-1 and writes NOP_WORD, one word per cycle. INIT -> RUN after the write at DEPTH-1, so INIT lasts exactly DEPTH cycles.
  - RUN: steady state.
- Reset values: state=INIT, counter=0, rsp_valid=0, rsp_instr=NOP_WORD, rsp_err=00, rsp_addr=0, busy=1, fetch_ready=0, load_ready=0.
- Mid-operation reset: reset asserted mid-INIT or mid-RUN returns to INIT immediately and drops rsp_valid. All memory contents are re-filled with NOP_WORD.
- busy is high exactly in INIT. fetch_ready = RUN && (!rsp_valid || rsp_ready). load_ready = RUN.
- Word index = addr[log2(DEPTH)+1:2].
- Fetch latency is 1 cycle. A request accepted at edge N gives rsp_valid=1 with its data after edge N.
- rsp_valid, rsp_instr, rsp_err and rsp_addr hold stable while rsp_valid && !rsp_ready.
- rsp_valid falls on the edge where rsp_ready=1 and no new request is accepted.
- Back-to-back operation: with rsp_ready held 1, one fetch completes per cycle.
- Error checks, in priority order:
  - addr[1:0] != 0 -> rsp_err=01.
  - else addr >= DEPTH*4 -> rsp_err=10.
  - On any error, rsp_instr=NOP_WORD and the RAM is not indexed.
- Load:
  - An accepted load writes mem[index] at the edge.
  - A misaligned or out-of-range load is dropped silently; no memory change.
- Simultaneous load and fetch to the same word in the same cycle: write-first. rsp_instr returns load_data.
- Loads and fetches are independent. A load never stalls a fetch.

Optional Feature:
IMEM_PARITY_EN:
- Defined:
  - Each word stores one extra even-parity bit, computed on every write (NOP fill and load).
  - A fetch whose stored parity mismatches returns rsp_err=11, with rsp_instr set to the raw stored data.
  - Adds input load_par_flip (1). When high during an accepted load, the stored parity bit is inverted, for test.
- Undefined: no parity storage, no load_par_flip port, and rsp_err never equals 11.

Test Plan:
- Reset, then idle DEPTH cycles -> busy=1 and fetch_ready=0 throughout; busy falls after cycle DEPTH; a fetch of 0x10 returns 32'h1800_0000, err 00.
- Load 0x18000000|10 at 0x0 and 32'h08000001 at 0x4, then fetch 0x0 and 0x4 back-to-back with rsp_ready=1 -> responses on consecutive cycles, correct data, rsp_addr echoes 0x0 then 0x4.
- Fetch 0x8 with rsp_ready=0 for 3 cycles -> rsp_valid stays 1, outputs stable, fetch_ready=0; rsp_ready=1 -> response consumed, fetch_ready=1.
- Fetch 0x6 -> err 01 with NOP_WORD; fetch DEPTH*4 (0x1000) -> err 10; load to 0x1000 -> no write, memory unchanged.
- Same-cycle load 0xDEADBEEF at 0x20 and fetch 0x20 -> rsp_instr=0xDEADBEEF. Then assert rst_n=0 mid-stream -> rsp_valid=0 at once; after INIT, fetch 0x20 returns NOP_WORD.
- (IMEM_PARITY_EN) load 0x20 with load_par_flip=1, then fetch 0x20 -> rsp_err=11.
